// File: rtl/simd_dispatch_ctrl.sv
// Dispatch controller for the SIMD datapath. It latches a command, streams operand pairs at up to
// one per cycle, tracks the in-flight pairs through the datapath latency and tags the results.
module simd_dispatch_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  // Command channel
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_instr,
  input  logic [5:0]  cmd_size,
  input  logic [5:0]  cmd_count,
  // Operand stream
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [63:0] op_a,
  input  logic [63:0] op_b,
  // To the SIMD datapath
  output logic        valid_instruction,
  output logic [2:0]  instruction,
  output logic [5:0]  data_size,
  output logic        valid_data,
  output logic [63:0] mc_data_in_opa,
  output logic [63:0] mc_data_in_opb,
  // From the SIMD datapath
  input  logic [31:0] out_procc0,
  input  logic [31:0] out_procc1,
  input  logic [31:0] out_extra_procc0,
  input  logic [31:0] out_extra_procc1,
  // Results and status
  output logic        res_valid,
  output logic [5:0]  res_index,
  output logic [31:0] res_procc0,
  output logic [31:0] res_procc1,
  output logic [31:0] res_extra0,
  output logic [31:0] res_extra1,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoad   = 3'd1;
  localparam logic [2:0] StStream = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  // All stages except the output stage; the output stage may still hold the last result
  // while the FSM already leaves DRAIN, so DONE follows it without a bubble.
  localparam logic [LATENCY-1:0] InnerMask = LATENCY'((64'd1 << (LATENCY - 1)) - 64'd1);

  logic [2:0]         state_q, state_d;
  logic [2:0]         instr_q;
  logic [5:0]         size_q;
  logic [5:0]         count_q;
  logic [5:0]         issue_cnt_q;
  logic [5:0]         res_idx_q;
  logic               valid_data_q;
  logic [63:0]        opa_q, opb_q;
  logic [LATENCY-1:0] sr_q, sr_d;

  logic cmd_fire;
  logic op_fire;
  logic last_pair;
  logic pending;

  assign cmd_ready = (state_q == StIdle);
  assign op_ready  = (state_q == StStream);
  assign cmd_fire  = cmd_valid & cmd_ready;
  assign op_fire   = op_valid & op_ready;
  assign last_pair = op_fire && ((issue_cnt_q + 6'd1) == count_q);
  assign pending   = valid_data_q || ((sr_q & InnerMask) != '0);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          state_d = (cmd_count == 6'd0) ? StDone : StLoad;
        end
      end
      StLoad:   state_d = StStream;
      StStream: if (last_pair) state_d = StDrain;
      StDrain:  if (!pending) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = valid_data_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      instr_q      <= '0;
      size_q       <= '0;
      count_q      <= '0;
      issue_cnt_q  <= '0;
      res_idx_q    <= '0;
      valid_data_q <= 1'b0;
      opa_q        <= '0;
      opb_q        <= '0;
      sr_q         <= '0;
    end else begin
      state_q      <= state_d;
      valid_data_q <= op_fire;
      sr_q         <= sr_d;

      if (cmd_fire) begin
        instr_q <= cmd_instr;
        size_q  <= cmd_size;
        count_q <= cmd_count;
      end

      if (cmd_fire) begin
        issue_cnt_q <= '0;
      end else if (op_fire) begin
        issue_cnt_q <= issue_cnt_q + 6'd1;
      end

      if (cmd_fire) begin
        res_idx_q <= '0;
      end else if (sr_q[LATENCY-1]) begin
        res_idx_q <= res_idx_q + 6'd1;
      end

      if (op_fire) begin
        opa_q <= op_a;
        opb_q <= op_b;
      end
    end
  end

  assign valid_instruction = (state_q == StLoad);
  assign instruction       = instr_q;
  assign data_size         = size_q;
  assign valid_data        = valid_data_q;
  assign mc_data_in_opa    = opa_q;
  assign mc_data_in_opb    = opb_q;

  assign res_valid  = sr_q[LATENCY-1];
  assign res_index  = res_idx_q;
  assign res_procc0 = out_procc0;
  assign res_procc1 = out_procc1;
  assign res_extra0 = out_extra_procc0;
  assign res_extra1 = out_extra_procc1;

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);

endmodule

// File: tb/tb_simd_dispatch_ctrl.sv
// Directed bench for simd_dispatch_ctrl with a result scoreboard keyed on due cycle and index.
module tb_simd_dispatch_ctrl;

  localparam int LAT = 2;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_instr;
  logic [5:0]  cmd_size;
  logic [5:0]  cmd_count;
  logic        op_valid;
  logic        op_ready;
  logic [63:0] op_a;
  logic [63:0] op_b;
  logic        valid_instruction;
  logic [2:0]  instruction;
  logic [5:0]  data_size;
  logic        valid_data;
  logic [63:0] mc_data_in_opa;
  logic [63:0] mc_data_in_opb;
  logic [31:0] out_procc0;
  logic [31:0] out_procc1;
  logic [31:0] out_extra_procc0;
  logic [31:0] out_extra_procc1;
  logic        res_valid;
  logic [5:0]  res_index;
  logic [31:0] res_procc0;
  logic [31:0] res_procc1;
  logic [31:0] res_extra0;
  logic [31:0] res_extra1;
  logic        busy;
  logic        done;

  simd_dispatch_ctrl #(.LATENCY(LAT)) dut (
    .clk               (clk),
    .reset             (reset),
    .cmd_valid         (cmd_valid),
    .cmd_ready         (cmd_ready),
    .cmd_instr         (cmd_instr),
    .cmd_size          (cmd_size),
    .cmd_count         (cmd_count),
    .op_valid          (op_valid),
    .op_ready          (op_ready),
    .op_a              (op_a),
    .op_b              (op_b),
    .valid_instruction (valid_instruction),
    .instruction       (instruction),
    .data_size         (data_size),
    .valid_data        (valid_data),
    .mc_data_in_opa    (mc_data_in_opa),
    .mc_data_in_opb    (mc_data_in_opb),
    .out_procc0        (out_procc0),
    .out_procc1        (out_procc1),
    .out_extra_procc0  (out_extra_procc0),
    .out_extra_procc1  (out_extra_procc1),
    .res_valid         (res_valid),
    .res_index         (res_index),
    .res_procc0        (res_procc0),
    .res_procc1        (res_procc1),
    .res_extra0        (res_extra0),
    .res_extra1        (res_extra1),
    .busy              (busy),
    .done              (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [5:0] idx;
  } res_t;

  res_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_vd = 0;
  int          n_res = 0;
  logic [5:0]  exp_idx = '0;
  logic [63:0] last_a = '0;
  logic [63:0] last_b = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock; the model decides from the inputs it drove what must appear after the edge.
  task automatic tick();
    logic        acc;
    logic        exp_rv;
    logic [63:0] a;
    logic [63:0] b;
    res_t        e;
    acc = !reset && op_valid && op_ready;
    a   = op_a;
    b   = op_b;
    if (!reset && cmd_valid && cmd_ready) exp_idx = '0;
    @(posedge clk);
    #1;
    cyc++;
    if (reset) begin
      sb.delete();
      last_a = '0;
      last_b = '0;
    end else if (acc) begin
      e.due = cyc + LAT;
      e.idx = exp_idx;
      sb.push_back(e);
      exp_idx = exp_idx + 6'd1;
      last_vd = cyc;
      last_a  = a;
      last_b  = b;
    end
    chk("valid_data", valid_data, acc);
    chk("mc_data_in_opa", mc_data_in_opa, last_a);
    chk("mc_data_in_opb", mc_data_in_opb, last_b);
    exp_rv = 1'b0;
    if (sb.size() > 0) begin
      if (sb[0].due == cyc) exp_rv = 1'b1;
    end
    chk("res_valid", res_valid, exp_rv);
    if (exp_rv && res_valid === 1'b1) begin
      e = sb.pop_front();
      n_res++;
      chk("res_index", res_index, e.idx);
      chk("res_procc0", res_procc0, out_procc0);
      chk("res_procc1", res_procc1, out_procc1);
      chk("res_extra0", res_extra0, out_extra_procc0);
      chk("res_extra1", res_extra1, out_extra_procc1);
    end else if (exp_rv) begin
      void'(sb.pop_front());
    end
    out_procc0       = $urandom();
    out_procc1       = $urandom();
    out_extra_procc0 = $urandom();
    out_extra_procc1 = $urandom();
  endtask

  // mode 0: op_valid every cycle, mode 1: op_valid toggling 1,0,1,0...
  task automatic run_cmd(input logic [2:0] instr, input logic [5:0] size, input logic [5:0] count,
                         input int mode, input int abort_after, input bit hold);
    int          n;
    int          guard;
    logic [31:0] hi;
    n_res = 0;
    chk("cmd_ready in idle", cmd_ready, 1'b1);
    chk("busy in idle", busy, 1'b0);
    cmd_valid = 1'b1;
    cmd_instr = instr;
    cmd_size  = size;
    cmd_count = count;
    tick();
    cmd_valid = hold;
    if (hold) begin
      cmd_instr = 3'b101;
      cmd_size  = 6'd12;
      cmd_count = 6'd2;
    end
    chk("busy after accept", busy, 1'b1);
    chk("cmd_ready after accept", cmd_ready, 1'b0);
    if (count == 6'd0) begin
      chk("done count0", done, 1'b1);
      chk("valid_instruction count0", valid_instruction, 1'b0);
      tick();
      chk("done pulse count0", done, 1'b0);
      chk("busy end count0", busy, 1'b0);
      chk("instruction held count0", instruction, instr);
      return;
    end
    chk("valid_instruction load", valid_instruction, 1'b1);
    chk("instruction load", instruction, instr);
    chk("data_size load", data_size, size);
    chk("op_ready load", op_ready, 1'b0);
    tick();
    chk("valid_instruction one cycle", valid_instruction, 1'b0);
    n = 0;
    guard = 0;
    while (n < int'(count) && guard < 300) begin
      chk("op_ready stream", op_ready, 1'b1);
      if (hold) chk("cmd_ready held off", cmd_ready, 1'b0);
      op_valid = (mode == 0) ? 1'b1 : ((guard % 2) == 0);
      hi = 32'h11111111 * 32'(n + 1);
      op_a = {hi, 32'h22222222};
      op_b = {hi, 32'h22222222} ^ 64'(n);
      tick();
      if (op_valid) n++;
      guard++;
      if (abort_after != 0 && n == abort_after) begin
        op_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("rst valid_instruction", valid_instruction, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst op_ready", op_ready, 1'b0);
        chk("rst instruction", instruction, 3'd0);
        chk("rst data_size", data_size, 6'd0);
        chk("rst res_index", res_index, 6'd0);
        reset = 1'b0;
        chk("cmd_ready after reset", cmd_ready, 1'b1);
        for (int i = 0; i < LAT + 4; i++) tick();
        chk("no results after abort", n_res, 0);
        return;
      end
    end
    op_valid = 1'b0;
    chk("op_ready drain", op_ready, 1'b0);
    guard = 0;
    while (done !== 1'b1 && guard < 100) begin
      if (hold) chk("cmd_ready held off drain", cmd_ready, 1'b0);
      tick();
      guard++;
    end
    chk("done cycle", cyc, last_vd + LAT + 1);
    chk("result count", n_res, count);
    chk("scoreboard empty", sb.size(), 0);
    tick();
    chk("done one cycle", done, 1'b0);
    chk("busy back to idle", busy, 1'b0);
    chk("instruction held", instruction, instr);
    chk("data_size held", data_size, size);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_instr = '0;
    cmd_size = '0;
    cmd_count = '0;
    op_valid = 1'b0;
    op_a = '0;
    op_b = '0;
    out_procc0 = '0;
    out_procc1 = '0;
    out_extra_procc0 = '0;
    out_extra_procc1 = '0;
    tick();
    tick();
    chk("reset cmd_ready", cmd_ready, 1'b1);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset op_ready", op_ready, 1'b0);
    chk("reset valid_instruction", valid_instruction, 1'b0);
    chk("reset instruction", instruction, 3'd0);
    chk("reset data_size", data_size, 6'd0);
    chk("reset res_index", res_index, 6'd0);
    reset = 1'b0;
    tick();

    run_cmd(3'b000, 6'd6, 6'd1, 0, 0, 1'b0);
    run_cmd(3'b010, 6'd8, 6'd6, 0, 0, 1'b0);
    run_cmd(3'b011, 6'd16, 6'd4, 1, 0, 1'b0);
    run_cmd(3'b100, 6'd32, 6'd0, 0, 0, 1'b0);
    run_cmd(3'b001, 6'd6, 6'd3, 0, 0, 1'b1);
    run_cmd(3'b101, 6'd12, 6'd2, 0, 0, 1'b0);
    run_cmd(3'b110, 6'd20, 6'd6, 0, 2, 1'b0);
    run_cmd(3'b111, 6'd6, 6'd5, 0, 0, 1'b0);
    run_cmd(3'b010, 6'd6, 6'd63, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
